// File: rtl/wasm_run_ctrl.sv
// Run controller for a WebAssembly CPU core: streams a program into instruction
// BRAM, holds the core in reset briefly, then supervises the run until a status flag or timeout.
module wasm_run_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_load_len,
    input  logic              i_ld_valid,
    input  logic [7:0]        i_ld_data,
    output logic              o_ld_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_cpu_rst_n,
    input  logic              i_cpu_finish,
    input  logic              i_cpu_error,
    input  logic              i_cpu_stack_full,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_status,
    output logic [CNT_W-1:0]  o_cycle_cnt
);

    localparam logic [ADDR_W:0]  MAX_LEN  = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_FINISHED  = 2'd0;
    localparam logic [1:0] ST_INSTR_ERR = 2'd1;
    localparam logic [1:0] ST_STACK     = 2'd2;
    localparam logic [1:0] ST_TIMEOUT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CPU_RST,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] idx_nxt;
    logic [ADDR_W:0] start_len;
    logic            rst_cnt;
    logic            accept;

    // Writes are suppressed during reset so a mid-load reset leaves BRAM untouched.
    assign accept      = o_ld_ready & i_ld_valid & ~i_rst;
    assign o_mem_we    = accept;
    assign o_mem_addr  = accept ? idx[ADDR_W-1:0] : '0;
    assign o_mem_wdata = accept ? i_ld_data : '0;
    assign idx_nxt     = idx + (ADDR_W+1)'(1);
    assign start_len   = (i_load_len > MAX_LEN) ? MAX_LEN : i_load_len;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            len         <= '0;
            idx         <= '0;
            rst_cnt     <= 1'b0;
            o_ld_ready  <= 1'b0;
            o_cpu_rst_n <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_status    <= '0;
            o_cycle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        len         <= start_len;
                        idx         <= '0;
                        rst_cnt     <= 1'b0;
                        o_done      <= 1'b0;
                        o_cycle_cnt <= '0;
                        o_busy      <= 1'b1;
                        o_cpu_rst_n <= 1'b0;
                        if (start_len != '0) begin
                            state      <= S_LOAD;
                            o_ld_ready <= 1'b1;
                        end else begin
                            state <= S_CPU_RST;
                        end
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        idx <= idx_nxt;
                        if (idx_nxt == len) begin
                            state      <= S_CPU_RST;
                            o_ld_ready <= 1'b0;
                            rst_cnt    <= 1'b0;
                        end
                    end
                end

                S_CPU_RST: begin
                    if (rst_cnt) begin
                        state       <= S_RUN;
                        o_cpu_rst_n <= 1'b1;
                    end else begin
                        rst_cnt <= 1'b1;
                    end
                end

                S_RUN: begin
                    // Counter holds on the exit cycle so it reports the sampling cycle.
                    if (i_cpu_error || i_cpu_stack_full || i_cpu_finish ||
                        o_cycle_cnt == CNT_LAST) begin
                        state       <= S_DONE;
                        o_done      <= 1'b1;
                        o_busy      <= 1'b0;
                        o_cpu_rst_n <= 1'b0;
                        if (i_cpu_error)
                            o_status <= ST_INSTR_ERR;
                        else if (i_cpu_stack_full)
                            o_status <= ST_STACK;
                        else if (i_cpu_finish)
                            o_status <= ST_FINISHED;
                        else
                            o_status <= ST_TIMEOUT;
                    end else if (o_cycle_cnt != '1) begin
                        o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
